// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI4-Stream frame generator.
// Beat-count and final-beat keep arithmetic live here so other AXIS sources can reuse them.
package axis_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // Widest beat (in byte lanes) the helpers support.
   localparam int MAX_KEEP = 128;

   // Low-lane mask with rem lanes set; rem == 0 means a full beat.
   function automatic logic [MAX_KEEP-1:0] keep_mask(input int unsigned rem,
                                                     input int unsigned keep_width);
      logic [MAX_KEEP-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_KEEP; i++) begin
         if ((rem == 0 && i < keep_width) || i < rem) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic int unsigned beats(input int unsigned len,
                                         input int unsigned keep_width);
      return (len + keep_width - 1) / keep_width;
   endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame source: one command in, one frame of incrementing bytes out.
// All stream outputs, cmd_ready, busy and frames_sent come straight from flops.
module axis_frame_gen
   import axis_pkg::*;
#(
   parameter int DWIDTH     = 32,
   parameter int KEEP_WIDTH = DWIDTH/8,
   parameter int LEN_WIDTH  = 16,
   parameter int ID_WIDTH   = 4,
   parameter int DEST_WIDTH = 4,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic [ID_WIDTH-1:0]   cmd_id,
   input  logic [DEST_WIDTH-1:0] cmd_dest,
   input  logic [7:0]            cmd_seed,
   output logic [DWIDTH-1:0]     m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [ID_WIDTH-1:0]   m_axis_tid,
   output logic [DEST_WIDTH-1:0] m_axis_tdest,
   output logic                  m_axis_tuser,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  frames_sent,
   output state_e                state_dbg
);

   // Handshakes: a transfer happens on the rising edge where valid && ready are
   // both high; a valid side holds its payload unchanged until that edge.

   state_e                state;
   logic [LEN_WIDTH-1:0]  beats_left;
   logic [7:0]            next_base;
   logic [KEEP_WIDTH-1:0] last_keep;

   int unsigned           len_u;
   logic [LEN_WIDTH-1:0]  cmd_beats;
   logic [KEEP_WIDTH-1:0] cmd_last_keep;
   logic [KEEP_WIDTH-1:0] first_keep;
   logic [KEEP_WIDTH-1:0] nxt_keep;

   assign state_dbg = state;

   // Lane i carries base+i; lanes outside keep are forced to zero.
   function automatic logic [DWIDTH-1:0] make_beat(input logic [7:0] base,
                                                   input logic [KEEP_WIDTH-1:0] keep);
      logic [DWIDTH-1:0] d;
      d = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         if (keep[i]) d[8*i +: 8] = base + 8'(i);
      end
      return d;
   endfunction

   always_comb begin
      len_u         = 32'(cmd_len);
      cmd_beats     = LEN_WIDTH'(beats(len_u, KEEP_WIDTH));
      cmd_last_keep = KEEP_WIDTH'(keep_mask(len_u % KEEP_WIDTH, KEEP_WIDTH));
      first_keep    = (cmd_beats == LEN_WIDTH'(1)) ? cmd_last_keep : '1;
      nxt_keep      = (beats_left == LEN_WIDTH'(1)) ? last_keep : '1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cmd_ready     <= 1'b0;
         busy          <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tid    <= '0;
         m_axis_tdest  <= '0;
         frames_sent   <= '0;
         beats_left    <= '0;
         next_base     <= '0;
         last_keep     <= '0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               // A zero-length command is swallowed without leaving IDLE.
               if (cmd_valid && cmd_ready && cmd_len != '0) begin
                  state         <= SEND;
                  cmd_ready     <= 1'b0;
                  busy          <= 1'b1;
                  m_axis_tvalid <= 1'b1;
                  m_axis_tuser  <= 1'b1;
                  m_axis_tlast  <= (cmd_beats == LEN_WIDTH'(1));
                  m_axis_tdata  <= make_beat(cmd_seed, first_keep);
                  m_axis_tkeep  <= first_keep;
                  m_axis_tid    <= cmd_id;
                  m_axis_tdest  <= cmd_dest;
                  beats_left    <= cmd_beats - LEN_WIDTH'(1);
                  next_base     <= cmd_seed + 8'(KEEP_WIDTH);
                  last_keep     <= cmd_last_keep;
               end
            end
            SEND: begin
               if (m_axis_tvalid && m_axis_tready) begin
                  if (m_axis_tlast) begin
                     state         <= IDLE;
                     cmd_ready     <= 1'b1;
                     busy          <= 1'b0;
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     m_axis_tuser  <= 1'b0;
                     m_axis_tdata  <= '0;
                     m_axis_tkeep  <= '0;
                     frames_sent   <= frames_sent + CNT_WIDTH'(1);
                  end else begin
                     m_axis_tuser <= 1'b0;
                     m_axis_tlast <= (beats_left == LEN_WIDTH'(1));
                     m_axis_tdata <= make_beat(next_base, nxt_keep);
                     m_axis_tkeep <= nxt_keep;
                     beats_left   <= beats_left - LEN_WIDTH'(1);
                     next_base    <= next_base + 8'(KEEP_WIDTH);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed and randomized bench for axis_frame_gen with a byte-level frame model.
module tb_axis_frame_gen;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_len;
   logic [3:0]  cmd_id;
   logic [3:0]  cmd_dest;
   logic [7:0]  cmd_seed;
   logic [31:0] m_axis_tdata;
   logic [3:0]  m_axis_tkeep;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [3:0]  m_axis_tid;
   logic [3:0]  m_axis_tdest;
   logic        m_axis_tuser;
   logic        busy;
   logic [31:0] frames_sent;
   axis_pkg::state_e state_dbg;

   int checks   = 0;
   int failures = 0;
   int exp_frames = 0;
   logic [63:0] exp_q[$];

   axis_frame_gen dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .cmd_id(cmd_id), .cmd_dest(cmd_dest), .cmd_seed(cmd_seed),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
      .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
      .busy(busy), .frames_sent(frames_sent), .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] obs_beat();
      return 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                  m_axis_tid, m_axis_tdest});
   endfunction

   // Reference: frame = byte stream seed, seed+1, ... cut into 4-byte beats.
   task automatic model_frame(input int len, input logic [7:0] seed,
                              input logic [3:0] id, input logic [3:0] dest);
      int nbeats;
      logic [31:0] d;
      logic [3:0]  k;
      nbeats = (len + 3) / 4;
      for (int b = 0; b < nbeats; b++) begin
         d = '0;
         k = '0;
         for (int i = 0; i < 4; i++) begin
            if (b*4 + i < len) begin
               d[8*i +: 8] = 8'((int'(seed) + b*4 + i) % 256);
               k[i] = 1'b1;
            end
         end
         exp_q.push_back(64'({d, k, (b == nbeats-1), (b == 0), id, dest}));
      end
   endtask

   task automatic send_cmd(input int len, input logic [7:0] seed,
                           input logic [3:0] id, input logic [3:0] dest);
      int budget;
      budget = 0;
      while (!cmd_ready && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_len   = 16'(len);
      cmd_seed  = seed;
      cmd_id    = id;
      cmd_dest  = dest;
      @(negedge clk);
      cmd_valid = 1'b0;
      model_frame(len, seed, id, dest);
      check("accept_tvalid", 64'(m_axis_tvalid), 64'd1);
      check("accept_busy", 64'(busy), 64'd1);
      check("accept_cmd_ready", 64'(cmd_ready), 64'd0);
   endtask

   // Consume expected beats under a random tready pattern; optionally spray
   // junk commands while the frame is in flight.
   task automatic drain(input int prob, input bit junk, input int stop_after,
                        output int cycles);
      int budget, accepted;
      bit acc;
      cycles = 0; budget = 0; accepted = 0;
      while (exp_q.size() > 0 && accepted < stop_after && budget < 4000) begin
         check("send_tvalid", 64'(m_axis_tvalid), 64'd1);
         check("send_busy", 64'(busy), 64'd1);
         check("send_cmd_ready", 64'(cmd_ready), 64'd0);
         check("beat", obs_beat(), exp_q[0]);
         acc = ($urandom_range(99, 0) < prob) && m_axis_tvalid;
         m_axis_tready = acc;
         if (junk) begin
            cmd_valid = 1'b1;
            cmd_len   = 16'($urandom);
            cmd_seed  = 8'($urandom);
            cmd_id    = 4'($urandom);
            cmd_dest  = 4'($urandom);
         end
         @(negedge clk);
         if (acc) begin
            if (exp_q[0][9]) exp_frames++;
            void'(exp_q.pop_front());
            accepted++;
         end
         cycles++;
         budget++;
      end
      cmd_valid     = 1'b0;
      m_axis_tready = 1'b0;
      if (accepted >= stop_after) return;
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      check("end_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("end_busy", 64'(busy), 64'd0);
      check("end_cmd_ready", 64'(cmd_ready), 64'd1);
      check("end_tlast", 64'(m_axis_tlast), 64'd0);
      check("frames_sent", 64'(frames_sent), 64'(exp_frames));
   endtask

   initial begin
      int cyc;
      int len;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_id = '0;
      cmd_dest = '0; cmd_seed = '0; m_axis_tready = 1'b0;

      #23;
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_outputs", obs_beat(), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_frames", 64'(frames_sent), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("release_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      check("first_edge_cmd_ready", 64'(cmd_ready), 64'd1);

      // 8 bytes from 0x10, sink always ready, one beat per cycle.
      send_cmd(8, 8'h10, 4'h3, 4'h5);
      drain(100, 1'b0, 1000, cyc);
      check("len8_cycles", 64'(cyc), 64'd2);
      check("len8_frames", 64'(frames_sent), 64'd1);

      // Byte wrap past 0xFF with a one-lane final beat.
      send_cmd(5, 8'hFE, 4'h1, 4'h2);
      drain(100, 1'b0, 1000, cyc);

      // Single-beat frame: tuser and tlast together.
      send_cmd(3, 8'h40, 4'hA, 4'hB);
      drain(100, 1'b0, 1000, cyc);
      check("len3_cycles", 64'(cyc), 64'd1);

      // 64 bytes with ~50% back-pressure and command noise.
      send_cmd(64, 8'($urandom), 4'($urandom), 4'($urandom));
      drain(50, 1'b1, 1000, cyc);

      // Zero-length command is swallowed.
      cmd_valid = 1'b1; cmd_len = '0; cmd_seed = 8'h77;
      @(negedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("len0_cmd_ready", 64'(cmd_ready), 64'd1);
      check("len0_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("len0_busy", 64'(busy), 64'd0);
      check("len0_frames", 64'(frames_sent), 64'(exp_frames));

      // Randomized frames, back to back.
      for (int f = 0; f < 14; f++) begin
         len = $urandom_range(40, 1);
         send_cmd(len, 8'($urandom), 4'($urandom), 4'($urandom));
         drain($urandom_range(100, 40), 1'($urandom), 1000, cyc);
      end

      // Reset asserted while beat 3 of an 8-beat frame is presented.
      send_cmd(32, 8'h20, 4'h6, 4'h7);
      drain(100, 1'b0, 3, cyc);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("midrst_tlast", 64'(m_axis_tlast), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_frames", 64'(frames_sent), 64'd0);
      check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
      exp_q.delete();
      exp_frames = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("midrst_release_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      check("midrst_edge_ready", 64'(cmd_ready), 64'd1);
      check("midrst_idle_tvalid", 64'(m_axis_tvalid), 64'd0);

      send_cmd(13, 8'hC3, 4'h9, 4'h4);
      drain(70, 1'b0, 1000, cyc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
